fft8_seq_ctrl: RTL
==================

Name: fft8_seq_ctrl

Overview:
- Sequencer for the 8-point radix-2 DIT FFT datapath.
- Detects the start pulse and loads 8 samples into working RAM in bit-reversed order.
- Schedules 3 stages × 4 butterflies onto one shared pipelined butterfly unit, with stage-boundary hazard stalls, then signals completion.
- Sits between the sample source and the butterfly/RAM/twiddle-ROM datapath; owns all addressing and enables.

Parameters:
- BF_LAT, 2, butterfly pipeline latency in cycles from read-issue to writeback (legal 1..8).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- input_pulse  in  1  start request; rising-edge detected.
- abort  in  1  synchronous abort; returns to IDLE.
- din_valid  in  1  sample-source valid.
- din_ready  out  1  high in LOAD.
- ld_we  out  1  RAM load write enable (= din_valid & din_ready, combinational).
- ld_addr  out  3  bit-reversed load address.
- bf_rd_en  out  1  butterfly issue strobe.
- bf_addr_a  out  3  top operand address.
- bf_addr_b  out  3  bottom operand address.
- bf_tw_idx  out  2  twiddle index k, for W8^k.
- bf_wr_en  out  1  writeback strobe.
- bf_wr_addr_a  out  3  writeback top address.
- bf_wr_addr_b  out  3  writeback bottom address.
- stage  out  2  current stage 0..2 (0 outside compute).
- busy  out  1  high in every state except IDLE.
- success  out  1  one-cycle done pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, edge-detect register 0, counters 0, writeback delay line cleared.
- Edge detect: start = input_pulse & ~input_pulse_q. input_pulse_q is registered every cycle. If input_pulse is high at reset release, it counts as an edge.
- Start is honoured only in IDLE. Edges while busy are dropped, not queued.
- States: IDLE → LOAD → ISSUE → WAIT → (ISSUE | DONE) → IDLE.
- IDLE: on start, go to LOAD next cycle and clear the load counter.
- LOAD:
  - din_ready = 1.
  - Each accepted cycle: ld_we = 1, ld_addr = bitrev3(cnt), cnt++. Sequence is 0,4,2,6,1,5,3,7.
  - After the 8th accept, go to ISSUE with stage = 0 and b = 0.
  - din_valid outside LOAD is ignored; ld_we stays 0.
- ISSUE: one butterfly per cycle for b = 0..3, with bf_rd_en = 1. For stage s:
  - span = 1<<s; pos = b & (span-1); grp = b >> s.
  - bf_addr_a = (grp << (s+1)) | pos.
  - bf_addr_b = bf_addr_a + span.
  - bf_tw_idx = pos << (2-s).
  - After b = 3, go to WAIT.
- Writeback: a BF_LAT-deep delay line carries the issue strobe and addresses. bf_wr_en and bf_wr_addr_a/b equal the values issued exactly BF_LAT cycles earlier.
- WAIT:
  - Hold for exactly BF_LAT cycles, so the stage's last writeback coincides with the final WAIT cycle.
  - Then: if stage < 2, stage++ and go to ISSUE. Else go to DONE.
  - Stage s+1 never reads before all stage-s writes complete.
- DONE: success = 1 for exactly one cycle, then IDLE. stage returns to 0.
- Timing: first ISSUE cycle = c. success is asserted at cycle c + 3·(4+BF_LAT), i.e. c+18 for BF_LAT=2.
- Address/index outputs are 0 whenever their strobe is low.
- abort:
  - Honoured in any non-IDLE state; next state is IDLE.
  - Delay line is flushed, so no bf_wr_en follows the abort.
  - success is not asserted.
  - abort in IDLE has no effect. abort and start in the same IDLE cycle: start wins.
- reset_n low mid-run: immediate return to reset values; any pending writebacks are discarded.

Test Plan:
- Reset with input_pulse=0, then a 5-cycle input_pulse, then din_valid held high → exactly one run.
  - ld_addr = 0,4,2,6,1,5,3,7.
  - success asserted once, 18 cycles after the first bf_rd_en (BF_LAT=2).
  - A second start edge during the run is ignored.
- Stage addressing, BF_LAT=2:
  - s0 (a,b,k) = (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - s1 = (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - s2 = (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - Each bf_wr_en lands 2 cycles after its issue with matching addresses.
- Hazard check, BF_LAT=5: no stage-(s+1) bf_rd_en before the final stage-s bf_wr_en. Total compute is 27 cycles.
- din_valid toggling 1,0,1,0…: LOAD takes 15 cycles. ld_we is asserted only on valid cycles; din_valid pulses while busy beyond LOAD produce no ld_we.
- abort asserted 1 cycle after stage-1 issue begins: next cycle busy = 0, then no bf_wr_en and no success. A subsequent start performs a clean full run.
- reset_n pulsed low during WAIT: outputs go to 0 asynchronously. After release with a new edge, the full sequence repeats correctly.

Source files
------------

// File: rtl/fft8_seq_ctrl.sv
// fft8_seq_ctrl: load/issue/writeback sequencer for an 8-point radix-2 DIT FFT
module fft8_seq_ctrl #(
    parameter int BF_LAT = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       input_pulse,
    input  logic       abort,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       ld_we,
    output logic [2:0] ld_addr,
    output logic       bf_rd_en,
    output logic [2:0] bf_addr_a,
    output logic [2:0] bf_addr_b,
    output logic [1:0] bf_tw_idx,
    output logic       bf_wr_en,
    output logic [2:0] bf_wr_addr_a,
    output logic [2:0] bf_wr_addr_b,
    output logic [1:0] stage,
    output logic       busy,
    output logic       success
);
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(BF_LAT - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic        pulse_q;
    logic        start;
    logic        flush;
    logic [2:0]  span;
    logic [2:0]  pos;
    logic [2:0]  grp;
    logic [2:0]  addr_a;
    logic [1:0]  tw;
    logic [BF_LAT-1:0] wb_en;
    logic [2:0]  wb_a [BF_LAT];
    logic [2:0]  wb_b [BF_LAT];

    assign start        = input_pulse & ~pulse_q;
    assign flush        = abort && state != IDLE;
    assign din_ready    = state == LOAD;
    assign ld_we        = din_valid & din_ready;
    assign ld_addr      = ld_we ? {cnt[0], cnt[1], cnt[2]} : 3'd0;
    assign busy         = state != IDLE;
    assign success      = state == DONE;
    assign bf_wr_en     = wb_en[BF_LAT-1];
    assign bf_wr_addr_a = wb_a[BF_LAT-1];
    assign bf_wr_addr_b = wb_b[BF_LAT-1];

    // butterfly operand addressing and twiddle index for the current stage and butterfly
    always_comb begin
        span      = 3'd1 << stage;
        pos       = {1'b0, cnt[1:0]} & (span - 3'd1);
        grp       = {1'b0, cnt[1:0]} >> stage;
        addr_a    = (grp << (stage + 2'd1)) | pos;
        tw        = pos[1:0] << (2'd2 - stage);
        bf_rd_en  = state == ISSUE;
        bf_addr_a = bf_rd_en ? addr_a : 3'd0;
        bf_addr_b = bf_rd_en ? addr_a + span : 3'd0;
        bf_tw_idx = bf_rd_en ? tw : 2'd0;
    end

    // sequencer: start edge detect, load counting, stage/butterfly scheduling, stage-boundary wait
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            stage   <= 2'd0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= input_pulse;
            if (flush) begin
                state <= IDLE;
                cnt   <= 3'd0;
                stage <= 2'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= LOAD;
                            cnt   <= 3'd0;
                        end
                    end
                    LOAD: begin
                        if (ld_we) begin
                            cnt <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                state <= ISSUE;
                                stage <= 2'd0;
                            end
                        end
                    end
                    ISSUE: begin
                        cnt <= cnt == 3'd3 ? 3'd0 : cnt + 3'd1;
                        if (cnt == 3'd3) state <= WAIT;
                    end
                    WAIT: begin
                        if (cnt == WAIT_LAST) begin
                            cnt   <= 3'd0;
                            state <= stage == 2'd2 ? DONE : ISSUE;
                            stage <= stage == 2'd2 ? 2'd0 : stage + 2'd1;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // writeback delay line: replays each issue strobe and its addresses BF_LAT cycles later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_en <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                wb_a[i] <= 3'd0;
                wb_b[i] <= 3'd0;
            end
        end else if (flush) begin
            wb_en <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                wb_a[i] <= 3'd0;
                wb_b[i] <= 3'd0;
            end
        end else begin
            wb_en[0] <= bf_rd_en;
            wb_a[0]  <= bf_addr_a;
            wb_b[0]  <= bf_addr_b;
            for (int i = 1; i < BF_LAT; i++) begin
                wb_en[i] <= wb_en[i-1];
                wb_a[i]  <= wb_a[i-1];
                wb_b[i]  <= wb_b[i-1];
            end
        end
    end
endmodule
